// File: rtl/mesi_isc_coherence_monitor.sv
// MESI coherence monitor: single-writer/multi-reader and encoding checks
// across all CPU caches, first-error capture, error counter, write watchdogs.
// Ports: clk, rst (async high), check_en, err_clr, cache_state (CPU-major,
// 4 bits per line), wr_req/wr_done (per CPU) in; err_valid, err_code,
// err_line, err_cpu, err_count, timeout_err out.
module mesi_isc_coherence_monitor #(
  parameter int CPU_COUNT  = 4,
  parameter int LINE_COUNT = 10,
  parameter int TIMEOUT    = 64,
  parameter int ERR_CNT_W  = 16,
  localparam int LW = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1,
  localparam int CW = $clog2(CPU_COUNT)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           check_en,
  input  logic                           err_clr,
  input  logic [CPU_COUNT*LINE_COUNT*4-1:0] cache_state,
  input  logic [CPU_COUNT-1:0]           wr_req,
  input  logic [CPU_COUNT-1:0]           wr_done,
  output logic                           err_valid,
  output logic [1:0]                     err_code,
  output logic [LW-1:0]                  err_line,
  output logic [CW-1:0]                  err_cpu,
  output logic [ERR_CNT_W-1:0]           err_count,
  output logic [CPU_COUNT-1:0]           timeout_err
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  localparam logic [3:0] ST_M = 4'b1001;
  localparam logic [3:0] ST_E = 4'b0101;
  localparam logic [3:0] ST_S = 4'b0011;
  localparam logic [3:0] ST_I = 4'b0000;

  typedef enum logic [1:0] {
    WD_IDLE,
    WD_WAIT,
    WD_EXP
  } wd_t;

  logic          any_err;
  logic [1:0]    cap_code;
  logic [LW-1:0] cap_line;
  logic [CW-1:0] cap_cpu;

  // Lines and CPUs are scanned from the top down so the last hit,
  // which wins, is the lowest index.
  always_comb begin : chk
    logic          ill;
    logic          me;
    logic          seen;
    logic          two;
    logic [CW-1:0] ill_cpu;
    logic [CW-1:0] me_cpu;
    logic [3:0]    s;
    any_err  = 1'b0;
    cap_code = 2'd0;
    cap_line = '0;
    cap_cpu  = '0;
    ill      = 1'b0;
    me       = 1'b0;
    seen     = 1'b0;
    two      = 1'b0;
    ill_cpu  = '0;
    me_cpu   = '0;
    s        = ST_I;
    for (int l = LINE_COUNT - 1; l >= 0; l--) begin
      ill     = 1'b0;
      me      = 1'b0;
      seen    = 1'b0;
      two     = 1'b0;
      ill_cpu = '0;
      me_cpu  = '0;
      for (int c = CPU_COUNT - 1; c >= 0; c--) begin
        s = cache_state[(c*LINE_COUNT+l)*4 +: 4];
        if (s != ST_M && s != ST_E &&
            s != ST_S && s != ST_I) begin
          ill     = 1'b1;
          ill_cpu = CW'(c);
        end
        if (s == ST_M || s == ST_E) begin
          me     = 1'b1;
          me_cpu = CW'(c);
        end
        if (s != ST_I) begin
          two  = two | seen;
          seen = 1'b1;
        end
      end
      if (check_en && (ill || (me && two))) begin
        any_err  = 1'b1;
        cap_code = ill ? 2'd2 : 2'd1;
        cap_cpu  = ill ? ill_cpu : me_cpu;
        cap_line = LW'(l);
      end
    end
  end

  wd_t                  wd_q   [CPU_COUNT];
  wd_t                  wd_d   [CPU_COUNT];
  logic [TW-1:0]        tmr_q  [CPU_COUNT];
  logic [TW-1:0]        tmr_d  [CPU_COUNT];
  logic [CPU_COUNT-1:0] expire;

  always_comb begin
    expire = '0;
    for (int c = 0; c < CPU_COUNT; c++) begin
      wd_d[c]  = wd_q[c];
      tmr_d[c] = tmr_q[c];
      if (!check_en) begin
        wd_d[c]  = WD_IDLE;
        tmr_d[c] = '0;
      end else begin
        unique case (wd_q[c])
          WD_IDLE: begin
            if (wr_req[c]) begin
              wd_d[c]  = WD_WAIT;
              tmr_d[c] = '0;
            end
          end
          WD_WAIT: begin
            if (wr_done[c]) begin
              wd_d[c] = WD_IDLE;
            end else if (tmr_q[c] == T_LAST) begin
              wd_d[c]   = WD_EXP;
              expire[c] = 1'b1;
            end else begin
              tmr_d[c] = tmr_q[c] + 1'b1;
            end
          end
          WD_EXP: begin
            if (wr_done[c]) wd_d[c] = WD_IDLE;
          end
          default: wd_d[c] = WD_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CPU_COUNT; c++) begin
        wd_q[c]  <= WD_IDLE;
        tmr_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CPU_COUNT; c++) begin
        wd_q[c]  <= wd_d[c];
        tmr_q[c] <= tmr_d[c];
      end
    end
  end

  // A clear and a new error in the same cycle: the error lands after
  // the clear, so the capture reloads and the count restarts at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid   <= 1'b0;
      err_code    <= 2'd0;
      err_line    <= '0;
      err_cpu     <= '0;
      err_count   <= '0;
      timeout_err <= '0;
    end else begin
      if (err_clr) begin
        err_valid <= 1'b0;
        err_code  <= 2'd0;
        err_line  <= '0;
        err_cpu   <= '0;
        err_count <= '0;
      end
      if (any_err && (!err_valid || err_clr)) begin
        err_valid <= 1'b1;
        err_code  <= cap_code;
        err_line  <= cap_line;
        err_cpu   <= cap_cpu;
      end
      if (any_err) begin
        if (err_clr)
          err_count <= ERR_CNT_W'(1);
        else if (!(&err_count))
          err_count <= err_count + 1'b1;
      end
      timeout_err <= (err_clr ? '0 : timeout_err) | expire;
    end
  end

endmodule

// File: tb/tb_mesi_isc_coherence_monitor.sv
// Self-checking bench for mesi_isc_coherence_monitor: vector table of
// coherence patterns plus hand sequences for watchdog, clear, saturation.
module tb_mesi_isc_coherence_monitor;

  localparam int CPUS  = 4;
  localparam int LINES = 10;
  localparam int TMO   = 64;

  localparam logic [3:0] M = 4'b1001;
  localparam logic [3:0] E = 4'b0101;
  localparam logic [3:0] S = 4'b0011;
  localparam logic [3:0] I = 4'b0000;

  logic clk = 1'b0;
  logic rst;
  logic check_en;
  logic err_clr;
  logic [CPUS*LINES*4-1:0] cache_state;
  logic [CPUS-1:0] wr_req;
  logic [CPUS-1:0] wr_done;

  logic        err_valid;
  logic [1:0]  err_code;
  logic [3:0]  err_line;
  logic [1:0]  err_cpu;
  logic [15:0] err_count;
  logic [3:0]  timeout_err;

  logic        v4;
  logic [1:0]  code4;
  logic [3:0]  line4;
  logic [1:0]  cpu4;
  logic [3:0]  cnt4;
  logic [3:0]  tmo4;

  always #5 clk = ~clk;

  mesi_isc_coherence_monitor #(
    .CPU_COUNT(CPUS), .LINE_COUNT(LINES),
    .TIMEOUT(TMO), .ERR_CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .check_en(check_en),
    .err_clr(err_clr), .cache_state(cache_state),
    .wr_req(wr_req), .wr_done(wr_done),
    .err_valid(err_valid), .err_code(err_code),
    .err_line(err_line), .err_cpu(err_cpu),
    .err_count(err_count), .timeout_err(timeout_err)
  );

  mesi_isc_coherence_monitor #(
    .CPU_COUNT(CPUS), .LINE_COUNT(LINES),
    .TIMEOUT(TMO), .ERR_CNT_W(4)
  ) dut4 (
    .clk(clk), .rst(rst), .check_en(check_en),
    .err_clr(err_clr), .cache_state(cache_state),
    .wr_req(wr_req), .wr_done(wr_done),
    .err_valid(v4), .err_code(code4),
    .err_line(line4), .err_cpu(cpu4),
    .err_count(cnt4), .timeout_err(tmo4)
  );

  typedef struct {
    string       name;
    logic        v;
    logic [1:0]  code;
    logic [3:0]  line;
    logic [1:0]  cpu;
    logic [15:0] cnt;
    logic [3:0]  tmo;
    bit          use4;
    logic [3:0]  cnt4;
  } exp_t;

  typedef struct {
    int         c[3];
    int         l[3];
    logic [3:0] s[3];
    logic [1:0] code;
    int         line;
    int         cpu;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(
    int c0, int l0, logic [3:0] s0,
    int c1, int l1, logic [3:0] s1,
    int c2, int l2, logic [3:0] s2,
    logic [1:0] code, int line, int cpu);
    vec_t r;
    r.c[0] = c0; r.l[0] = l0; r.s[0] = s0;
    r.c[1] = c1; r.l[1] = l1; r.s[1] = s1;
    r.c[2] = c2; r.l[2] = l2; r.s[2] = s2;
    r.code = code;
    r.line = line;
    r.cpu  = cpu;
    return r;
  endfunction

  function automatic exp_t mke(
    string nm, logic v, logic [1:0] code, int line, int cpu,
    int cnt, logic [3:0] tmo);
    exp_t e;
    e.name = nm;
    e.v    = v;
    e.code = code;
    e.line = 4'(line);
    e.cpu  = 2'(cpu);
    e.cnt  = 16'(cnt);
    e.tmo  = tmo;
    e.use4 = 1'b0;
    e.cnt4 = '0;
    return e;
  endfunction

  task automatic push(
    string nm, logic v, logic [1:0] code, int line, int cpu,
    int cnt, logic [3:0] tmo);
    sb.push_back(mke(nm, v, code, line, cpu, cnt, tmo));
  endtask

  task automatic compare(exp_t e);
    bit bad;
    n_cmp++;
    bad = ({err_valid, err_code, err_line, err_cpu, err_count,
            timeout_err} !==
           {e.v, e.code, e.line, e.cpu, e.cnt, e.tmo}) ||
          ({v4, code4, line4, cpu4, tmo4} !==
           {e.v, e.code, e.line, e.cpu, e.tmo}) ||
          (e.use4 && cnt4 !== e.cnt4);
    if (bad) begin
      n_bad++;
      $display("FAIL %s: got v=%0b code=%0d line=%0d cpu=%0d cnt=%0d tmo=%b cnt4=%0d | want v=%0b code=%0d line=%0d cpu=%0d cnt=%0d tmo=%b cnt4=%0d(chk=%0b) | w4 v=%0b code=%0d line=%0d cpu=%0d tmo=%b",
               e.name, err_valid, err_code, err_line, err_cpu,
               err_count, timeout_err, cnt4, e.v, e.code, e.line,
               e.cpu, e.cnt, e.tmo, e.cnt4, e.use4,
               v4, code4, line4, cpu4, tmo4);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      compare(e);
    end
  endtask

  task automatic set_line(int c, int l, logic [3:0] s);
    cache_state[(c*LINES+l)*4 +: 4] = s;
  endtask

  vec_t vt[11];
  exp_t ex;

  initial begin
    vt[0]  = mk(0,0,I, 0,0,I, 0,0,I, 2'd0, 0, 0);
    vt[1]  = mk(1,3,M, 2,3,S, 0,0,I, 2'd1, 3, 1);
    vt[2]  = mk(0,7,E, 3,7,E, 2,2,4'b0110, 2'd2, 2, 2);
    vt[3]  = mk(0,0,M, 1,0,M, 0,1,I, 2'd1, 0, 0);
    vt[4]  = mk(2,5,M, 0,9,S, 1,9,S, 2'd0, 0, 0);
    vt[5]  = mk(3,4,E, 1,4,S, 0,0,I, 2'd1, 4, 3);
    vt[6]  = mk(3,9,4'hF, 1,6,E, 2,6,E, 2'd1, 6, 1);
    vt[7]  = mk(0,1,M, 1,1,S, 3,1,4'b0001, 2'd2, 1, 3);
    vt[8]  = mk(2,8,E, 3,8,M, 0,0,I, 2'd1, 8, 2);
    vt[9]  = mk(0,5,E, 2,5,S, 3,5,S, 2'd1, 5, 0);
    vt[10] = mk(1,0,4'b1000, 0,0,I, 0,0,I, 2'd2, 0, 1);

    rst         = 1'b1;
    check_en    = 1'b0;
    err_clr     = 1'b0;
    cache_state = '0;
    wr_req      = '0;
    wr_done     = '0;
    repeat (2) @(posedge clk);
    #1;
    ex = mke("reset", 0, 0, 0, 0, 0, 4'b0000);
    ex.use4 = 1'b1;
    compare(ex);
    rst = 1'b0;

    // All lines I for 100 cycles
    check_en = 1'b1;
    repeat (99) tick();
    push("idle100", 0, 0, 0, 0, 0, 4'b0000);
    tick();

    // Vector table, each pattern applied with err_clr in the same cycle
    foreach (vt[k]) begin
      cache_state = '0;
      for (int j = 0; j < 3; j++)
        set_line(vt[k].c[j], vt[k].l[j], vt[k].s[j]);
      err_clr = 1'b1;
      push($sformatf("vec%0d", k), vt[k].code != 0, vt[k].code,
           vt[k].line, vt[k].cpu, (vt[k].code != 0) ? 1 : 0, 4'b0000);
      tick();
      err_clr     = 1'b0;
      cache_state = '0;
      push($sformatf("vec%0d_hold", k), vt[k].code != 0, vt[k].code,
           vt[k].line, vt[k].cpu, (vt[k].code != 0) ? 1 : 0, 4'b0000);
      tick();
    end

    // M/S on line 3 held three cycles, then a later error does not overwrite
    err_clr = 1'b1;
    push("clr_b", 0, 0, 0, 0, 0, 4'b0000);
    tick();
    err_clr = 1'b0;
    set_line(1, 3, M);
    set_line(2, 3, S);
    for (int k = 1; k <= 3; k++) begin
      push($sformatf("ms_cnt%0d", k), 1, 1, 3, 1, k, 4'b0000);
      tick();
    end
    set_line(0, 0, M);
    set_line(1, 0, M);
    push("no_overwrite", 1, 1, 3, 1, 4, 4'b0000);
    tick();
    check_en = 1'b0;
    push("chk_off_hold1", 1, 1, 3, 1, 4, 4'b0000);
    tick();
    push("chk_off_hold2", 1, 1, 3, 1, 4, 4'b0000);
    tick();
    check_en    = 1'b1;
    cache_state = '0;
    push("chk_on_clean", 1, 1, 3, 1, 4, 4'b0000);
    tick();

    // Saturation of the 4-bit counter
    err_clr = 1'b1;
    push("clr_sat", 0, 0, 0, 0, 0, 4'b0000);
    tick();
    err_clr = 1'b0;
    set_line(1, 3, M);
    set_line(2, 3, S);
    for (int k = 1; k <= 20; k++) begin
      ex = mke($sformatf("sat%0d", k), 1, 1, 3, 1, k, 4'b0000);
      ex.use4 = 1'b1;
      ex.cnt4 = (k > 15) ? 4'd15 : 4'(k);
      sb.push_back(ex);
      tick();
    end
    cache_state = '0;

    // Watchdog: done exactly at the last allowed edge
    err_clr = 1'b1;
    push("clr_wd", 0, 0, 0, 0, 0, 4'b0000);
    tick();
    err_clr = 1'b0;
    wr_req[0] = 1'b1;
    tick();
    wr_req[0] = 1'b0;
    repeat (63) tick();
    wr_done[0] = 1'b1;
    push("wd_done_last", 0, 0, 0, 0, 0, 4'b0000);
    tick();
    wr_done[0] = 1'b0;
    repeat (70) tick();
    push("wd_back_idle", 0, 0, 0, 0, 0, 4'b0000);
    tick();

    // Watchdog: no done, expiry boundary
    wr_req[0] = 1'b1;
    tick();
    wr_req[0] = 1'b0;
    repeat (62) tick();
    push("wd_edge63", 0, 0, 0, 0, 0, 4'b0000);
    tick();
    push("wd_edge64", 0, 0, 0, 0, 0, 4'b0001);
    tick();
    wr_done[0] = 1'b1;
    push("wd_sticky", 0, 0, 0, 0, 0, 4'b0001);
    tick();
    wr_done[0] = 1'b0;

    // Done on the first edge after req
    wr_req[2] = 1'b1;
    tick();
    wr_req[2]  = 1'b0;
    wr_done[2] = 1'b1;
    tick();
    wr_done[2] = 1'b0;
    repeat (70) tick();
    push("wd_done_first", 0, 0, 0, 0, 0, 4'b0001);
    tick();

    // req and done together in IDLE still start the watchdog
    wr_req[3]  = 1'b1;
    wr_done[3] = 1'b1;
    tick();
    wr_req[3]  = 1'b0;
    wr_done[3] = 1'b0;
    repeat (62) tick();
    push("wd_reqdone63", 0, 0, 0, 0, 0, 4'b0001);
    tick();
    push("wd_reqdone64", 0, 0, 0, 0, 0, 4'b1001);
    tick();

    // check_en low forces the watchdog idle
    wr_req[1] = 1'b1;
    tick();
    wr_req[1] = 1'b0;
    repeat (10) tick();
    check_en = 1'b0;
    tick();
    check_en = 1'b1;
    repeat (70) tick();
    push("wd_forced_idle", 0, 0, 0, 0, 0, 4'b1001);
    tick();
    check_en  = 1'b0;
    wr_req[1] = 1'b1;
    tick();
    check_en  = 1'b1;
    wr_req[1] = 1'b0;
    repeat (70) tick();
    push("wd_req_chk_off", 0, 0, 0, 0, 0, 4'b1001);
    tick();

    // err_clr in the same cycle as a new M/M on line 0
    set_line(0, 5, M);
    set_line(1, 5, E);
    push("pre_clr_err", 1, 1, 5, 0, 1, 4'b1001);
    tick();
    cache_state = '0;
    set_line(2, 0, M);
    set_line(3, 0, M);
    err_clr = 1'b1;
    push("clr_same_cycle", 1, 1, 0, 2, 1, 4'b0000);
    tick();
    err_clr     = 1'b0;
    cache_state = '0;
    push("clr_same_hold", 1, 1, 0, 2, 1, 4'b0000);
    tick();

    // Asynchronous reset mid-WAIT and mid-error
    cache_state = '0;
    set_line(0, 2, M);
    set_line(1, 2, M);
    err_clr   = 1'b1;
    wr_req[0] = 1'b1;
    push("pre_rst", 1, 1, 2, 0, 1, 4'b0000);
    tick();
    err_clr   = 1'b0;
    wr_req[0] = 1'b0;
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    ex = mke("async_rst", 0, 0, 0, 0, 0, 4'b0000);
    ex.use4 = 1'b1;
    compare(ex);
    rst         = 1'b0;
    cache_state = '0;
    repeat (70) tick();
    push("post_rst_idle", 0, 0, 0, 0, 0, 4'b0000);
    tick();

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
